aes_ctr_stream: RTL and testbench

AES_CTR_STREAM -- requirements
Module: aes_ctr_stream

---
 rtl/aes_ctr_stream.sv | 201 ++++++++++++++++++++
 tb/tb_aes_ctr_stream.sv | 351 +++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/aes_ctr_stream.sv
// aes_ctr_stream: CTR-mode sequencer around an external block cipher core.
// Prefetches keystream blocks into a FIFO and XORs them onto plaintext.
module aes_ctr_stream #(
    parameter int CTR_W    = 32,
    parameter int KS_DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_n,
    input  logic             en_i,
    input  logic             start_i,
    input  logic [127:0]     iv_i,
    output logic             core_req_o,
    output logic [127:0]     core_block_o,
    input  logic             core_ready_i,
    input  logic             core_valid_i,
    input  logic [127:0]     core_block_i,
    input  logic             pt_valid_i,
    input  logic [127:0]     pt_data_i,
    input  logic             pt_last_i,
    output logic             pt_ready_o,
    output logic             ct_valid_o,
    output logic [127:0]     ct_data_o,
    output logic             ct_last_o,
    input  logic             ct_ready_i,
    output logic             busy_o,
    output logic             done_o,
    output logic             wrap_o,
    output logic [CTR_W-1:0] blk_cnt_o
);
    localparam int AW = $clog2(KS_DEPTH);
    localparam logic [AW:0] DEPTH = (AW+1)'(KS_DEPTH);

    typedef enum logic [2:0] {
        IDLE,
        ISSUE,
        WAIT,
        FULL,
        HALT
    } state_t;

    state_t state;
    state_t state_nxt;

    logic [127:0]     ctr;
    logic [CTR_W-1:0] blk_cnt;
    logic             wrap;
    logic             done;
    logic             drop;
    logic             drop_nxt;

    logic [127:0]     mem [KS_DEPTH];
    logic [AW:0]      wr_ptr;
    logic [AW:0]      rd_ptr;
    logic [AW:0]      count;
    logic [AW:0]      count_push;
    logic [127:0]     head;
    logic             empty;

    logic             xfer;
    logic             last_xfer;
    logic             issue_ok;
    logic             push;
    logic             flush;
    logic             load;

    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign head       = mem[rd_ptr[AW-1:0]];
    assign count_push = count + (AW+1)'(1)
                        - (AW+1)'(xfer);

    assign busy_o       = (state != IDLE);
    assign core_req_o   = en_i & (state == ISSUE);
    assign core_block_o = (state == ISSUE) ? ctr : '0;
    assign ct_valid_o   = en_i & pt_valid_i & ~empty & busy_o;
    assign pt_ready_o   = en_i & ct_ready_i & ~empty & busy_o;

    // Data path is forced quiet while reset is held
    assign ct_data_o = rst_n ? (pt_data_i ^ head) : '0;
    assign ct_last_o = rst_n & pt_last_i;

    assign xfer      = ct_valid_o & ct_ready_i;
    assign last_xfer = xfer & pt_last_i;
    assign issue_ok  = core_req_o & core_ready_i;

    assign done_o    = done;
    assign wrap_o    = wrap;
    assign blk_cnt_o = blk_cnt;

    always_comb begin
        state_nxt = state;
        drop_nxt  = drop;
        load      = 1'b0;
        flush     = 1'b0;
        push      = 1'b0;
        unique case (state)
            IDLE: begin
                if (start_i) begin
                    state_nxt = ISSUE;
                    load      = 1'b1;
                    flush     = 1'b1;
                end
            end
            ISSUE: begin
                if (last_xfer) begin
                    state_nxt = issue_ok ? WAIT : IDLE;
                    drop_nxt  = issue_ok;
                end else if (issue_ok) begin
                    state_nxt = WAIT;
                end
            end
            WAIT: begin
                if (drop || last_xfer) begin
                    // session is over; swallow the in-flight response
                    drop_nxt = 1'b1;
                    if (core_valid_i) begin
                        state_nxt = IDLE;
                        drop_nxt  = 1'b0;
                    end
                end else if (core_valid_i) begin
                    push = 1'b1;
                    if (wrap)
                        state_nxt = HALT;
                    else if (count_push < DEPTH)
                        state_nxt = ISSUE;
                    else
                        state_nxt = FULL;
                end
            end
            FULL: begin
                if (last_xfer)
                    state_nxt = IDLE;
                else if (count < DEPTH)
                    state_nxt = ISSUE;
            end
            HALT: begin
                if (last_xfer)
                    state_nxt = IDLE;
            end
            default: begin
                state_nxt = IDLE;
                drop_nxt  = 1'b0;
            end
        endcase
        if (state != IDLE && state_nxt == IDLE)
            flush = 1'b1;
        if (last_xfer)
            flush = 1'b1;
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            drop    <= 1'b0;
            ctr     <= '0;
            wrap    <= 1'b0;
            blk_cnt <= '0;
            done    <= 1'b0;
        end else if (en_i) begin
            state <= state_nxt;
            drop  <= drop_nxt;
            done  <= last_xfer;
            if (load) begin
                ctr     <= iv_i;
                wrap    <= 1'b0;
                blk_cnt <= '0;
            end else begin
                if (issue_ok) begin
                    ctr[CTR_W-1:0] <= ctr[CTR_W-1:0]
                                      + CTR_W'(1);
                    if (&ctr[CTR_W-1:0])
                        wrap <= 1'b1;
                end
                if (xfer)
                    blk_cnt <= blk_cnt + CTR_W'(1);
            end
        end
    end

    always_ff @(posedge clk_i or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            for (int i = 0; i < KS_DEPTH; i++)
                mem[i] <= '0;
        end else if (en_i) begin
            if (flush) begin
                wr_ptr <= '0;
                rd_ptr <= '0;
            end else begin
                if (push) begin
                    mem[wr_ptr[AW-1:0]] <= core_block_i;
                    wr_ptr <= wr_ptr + (AW+1)'(1);
                end
                if (xfer)
                    rd_ptr <= rd_ptr + (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_aes_ctr_stream.sv
// tb_aes_ctr_stream: directed sessions with an identity core (2-cycle latency)
// checked against a counter-block keystream model.
module tb_aes_ctr_stream;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         en_i = 1'b1;
    logic         start_i = 1'b0;
    logic [127:0] iv_i = '0;
    logic         core_req_o;
    logic [127:0] core_block_o;
    logic         core_ready_i = 1'b1;
    logic         core_valid_i = 1'b0;
    logic [127:0] core_block_i = '0;
    logic         pt_valid_i = 1'b0;
    logic [127:0] pt_data_i = '0;
    logic         pt_last_i = 1'b0;
    logic         pt_ready_o;
    logic         ct_valid_o;
    logic [127:0] ct_data_o;
    logic         ct_last_o;
    logic         ct_ready_i = 1'b1;
    logic         busy_o;
    logic         done_o;
    logic         wrap_o;
    logic [31:0]  blk_cnt_o;

    always #5 clk = ~clk;

    aes_ctr_stream dut (
        .clk_i        (clk),
        .rst_n        (rst_n),
        .en_i         (en_i),
        .start_i      (start_i),
        .iv_i         (iv_i),
        .core_req_o   (core_req_o),
        .core_block_o (core_block_o),
        .core_ready_i (core_ready_i),
        .core_valid_i (core_valid_i),
        .core_block_i (core_block_i),
        .pt_valid_i   (pt_valid_i),
        .pt_data_i    (pt_data_i),
        .pt_last_i    (pt_last_i),
        .pt_ready_o   (pt_ready_o),
        .ct_valid_o   (ct_valid_o),
        .ct_data_o    (ct_data_o),
        .ct_last_o    (ct_last_o),
        .ct_ready_i   (ct_ready_i),
        .busy_o       (busy_o),
        .done_o       (done_o),
        .wrap_o       (wrap_o),
        .blk_cnt_o    (blk_cnt_o)
    );

    // identity core: answer two enabled cycles after acceptance
    int           lat = 0;
    logic [127:0] pend = '0;
    logic         en_seen = 1'b1;

    always @(negedge clk) begin
        if (core_valid_i && en_seen)
            core_valid_i = 1'b0;
        if (lat > 0 && en_i) begin
            lat = lat - 1;
            if (lat == 0) begin
                core_valid_i = 1'b1;
                core_block_i = pend;
            end
        end
        if (core_req_o && core_ready_i) begin
            lat  = 2;
            pend = core_block_o;
        end
        en_seen = en_i;
    end

    int           n_cmp = 0;
    int           n_fail = 0;
    logic [127:0] m_iv = '0;
    int           req_cnt = 0;
    int           xfer_cnt = 0;
    int           done_cnt = 0;
    logic [127:0] ct_log [$];
    logic [127:0] req_log [$];

    function automatic logic [127:0] ks(
        input logic [127:0] iv, input int k);
        logic [31:0] lo;
        lo = iv[31:0] + 32'(k);
        return {iv[127:32], lo};
    endfunction

    function automatic logic [127:0] pt_pat(input int i);
        return {32'hFFFF0000 ^ 32'(i), 32'h0000FFFF,
                32'h12345678, 32'hF0F0F0F0};
    endfunction

    task automatic chk(input string name,
                       input logic [127:0] act,
                       input logic [127:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h want %h", name, act, exp);
        end
    endtask

    task automatic chk_zero(input string name);
        chk({name, "_blocks"}, core_block_o | ct_data_o, '0);
        chk({name, "_flags"},
            128'({core_req_o, pt_ready_o, ct_valid_o, ct_last_o,
                  busy_o, done_o, wrap_o, blk_cnt_o}), '0);
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic start_session(input logic [127:0] iv);
        iv_i     = iv;
        start_i  = 1'b1;
        m_iv     = iv;
        req_cnt  = 0;
        xfer_cnt = 0;
        done_cnt = 0;
        ct_log.delete();
        req_log.delete();
        tick(1);
        start_i = 1'b0;
    endtask

    task automatic send(input int first, input int n,
                        input bit with_last);
        for (int i = 0; i < n; i++) begin
            bit hs;
            hs         = 1'b0;
            pt_valid_i = 1'b1;
            pt_data_i  = pt_pat(first + i);
            pt_last_i  = with_last && (i == n - 1);
            ct_ready_i = 1'b1;
            for (int c = 0; c < 80 && !hs; c++) begin
                @(negedge clk);
                hs = ct_valid_o && ct_ready_i;
                tick(1);
            end
            if (!hs) begin
                n_cmp++;
                n_fail++;
                $display("FAIL send_timeout: block %0d not taken in 80 cycles",
                         first + i);
                pt_valid_i = 1'b0;
                pt_last_i  = 1'b0;
                return;
            end
        end
        pt_valid_i = 1'b0;
        pt_last_i  = 1'b0;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int frz_req;

        fork
            forever begin
                @(negedge clk);
                if (rst_n) begin
                    if (core_req_o && core_ready_i) begin
                        chk("req_block", core_block_o, ks(m_iv, req_cnt));
                        req_log.push_back(core_block_o);
                        req_cnt++;
                    end
                    if (ct_valid_o && ct_ready_i) begin
                        chk("ct_data", ct_data_o,
                            pt_data_i ^ ks(m_iv, xfer_cnt));
                        chk("ct_last", 128'(ct_last_o), 128'(pt_last_i));
                        chk("blk_cnt", 128'(blk_cnt_o), 128'(xfer_cnt));
                        ct_log.push_back(ct_data_o);
                        xfer_cnt++;
                    end
                    if (!en_i)
                        chk("en_gate",
                            128'({core_req_o, ct_valid_o, pt_ready_o}), '0);
                    if (done_o)
                        done_cnt++;
                end
            end
        join_none

        // reset: every output reads zero even with live plaintext
        #2;
        pt_valid_i = 1'b1;
        pt_data_i  = pt_pat(5);
        pt_last_i  = 1'b1;
        #1;
        chk_zero("reset");
        pt_valid_i = 1'b0;
        pt_last_i  = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("reset_busy", 128'(busy_o), 128'(0));

        // basic session, three blocks
        start_session({96'h00112233_44556677_8899AABB, 32'h0});
        send(0, 3, 1'b1);
        tick(6);
        chk("t1_nblk", 128'(ct_log.size()), 128'(3));
        if (ct_log.size() == 3) begin
            chk("t1_ct0", ct_log[0],
                128'hFFEE2233_44559988_9AADFCC3_F0F0F0F0);
            chk("t1_ct1", ct_log[1],
                128'hFFEE2232_44559988_9AADFCC3_F0F0F0F1);
            chk("t1_ct2", ct_log[2],
                128'hFFEE2231_44559988_9AADFCC3_F0F0F0F2);
        end
        chk("t1_done", 128'(done_cnt), 128'(1));
        chk("t1_busy", 128'(busy_o), 128'(0));
        chk("t1_blk", 128'(blk_cnt_o), 128'(3));
        chk("t1_wrap", 128'(wrap_o), 128'(0));

        // back-pressure fills the prefetch FIFO
        start_session({96'hCAFEF00D_0BADC0DE_13579BDF, 32'h10});
        ct_ready_i = 1'b0;
        pt_valid_i = 1'b1;
        pt_data_i  = pt_pat(0);
        pt_last_i  = 1'b0;
        tick(20);
        chk("t2_reqs", 128'(req_cnt), 128'(4));
        chk("t2_req_off", 128'(core_req_o), 128'(0));
        chk("t2_busy", 128'(busy_o), 128'(1));
        chk("t2_ctv", 128'(ct_valid_o), 128'(1));
        chk("t2_ptr", 128'(pt_ready_o), 128'(0));
        send(0, 1, 1'b0);
        tick(8);
        chk("t2_refill", 128'(req_cnt), 128'(5));
        chk("t2_req_off2", 128'(core_req_o), 128'(0));
        send(1, 3, 1'b1);
        tick(8);
        chk("t2_done", 128'(done_cnt), 128'(1));
        chk("t2_busy_end", 128'(busy_o), 128'(0));
        chk("t2_blk", 128'(blk_cnt_o), 128'(4));

        // last on the first block while a response is in flight
        start_session({96'h01020304_05060708_090A0B0C, 32'h100});
        send(0, 1, 1'b1);
        tick(8);
        chk("t4_busy", 128'(busy_o), 128'(0));
        chk("t4_done", 128'(done_cnt), 128'(1));
        chk("t4_reqs", 128'(req_cnt), 128'(2));
        pt_valid_i = 1'b1;
        pt_data_i  = pt_pat(9);
        @(negedge clk);
        chk("t4_ctv_idle", 128'(ct_valid_o), 128'(0));
        tick(1);
        pt_valid_i = 1'b0;
        start_session({96'h0F0E0D0C_0B0A0908_07060504, 32'h7});
        send(0, 2, 1'b1);
        tick(8);
        chk("t4_restart_blk", 128'(blk_cnt_o), 128'(2));
        chk("t4_restart_done", 128'(done_cnt), 128'(1));
        chk("t4_restart_busy", 128'(busy_o), 128'(0));

        // hold for five cycles mid-stream
        start_session({96'hA0A1A2A3_B0B1B2B3_C0C1C2C3, 32'h55});
        send(0, 2, 1'b0);
        pt_valid_i = 1'b1;
        pt_data_i  = pt_pat(2);
        pt_last_i  = 1'b0;
        en_i       = 1'b0;
        frz_req    = req_cnt;
        repeat (5) begin
            @(negedge clk);
            chk("t5_blk_frozen", 128'(blk_cnt_o), 128'(2));
            chk("t5_busy", 128'(busy_o), 128'(1));
        end
        @(posedge clk);
        #1;
        chk("t5_req_frozen", 128'(req_cnt), 128'(frz_req));
        en_i = 1'b1;
        send(2, 3, 1'b1);
        tick(8);
        chk("t5_blk", 128'(blk_cnt_o), 128'(5));
        chk("t5_done", 128'(done_cnt), 128'(1));
        chk("t5_busy_end", 128'(busy_o), 128'(0));

        // counter wrap stops issuing
        start_session({96'hDEADBEEF_01234567_89ABCDEF, 32'hFFFFFFFE});
        send(0, 2, 1'b0);
        tick(6);
        chk("t3_wrap", 128'(wrap_o), 128'(1));
        chk("t3_reqs", 128'(req_cnt), 128'(2));
        if (req_log.size() == 2) begin
            chk("t3_req0", req_log[0],
                128'hDEADBEEF_01234567_89ABCDEF_FFFFFFFE);
            chk("t3_req1", req_log[1],
                128'hDEADBEEF_01234567_89ABCDEF_FFFFFFFF);
        end
        pt_valid_i = 1'b1;
        pt_data_i  = pt_pat(2);
        @(negedge clk);
        chk("t3_ptr", 128'(pt_ready_o), 128'(0));
        chk("t3_ctv", 128'(ct_valid_o), 128'(0));
        chk("t3_req_off", 128'(core_req_o), 128'(0));
        chk("t3_busy", 128'(busy_o), 128'(1));
        tick(1);
        pt_valid_i = 1'b0;
        rst_n = 1'b0;
        tick(2);
        rst_n = 1'b1;
        tick(1);
        chk("t3_wrap_rst", 128'(wrap_o), 128'(0));
        chk("t3_busy_rst", 128'(busy_o), 128'(0));

        // asynchronous reset while waiting on the core
        pt_valid_i = 1'b1;
        pt_data_i  = pt_pat(7);
        pt_last_i  = 1'b1;
        start_session({96'h11111111_22222222_33333333, 32'h44});
        @(posedge clk);
        #2;
        chk("t6_in_wait_busy", 128'(busy_o), 128'(1));
        chk("t6_in_wait_req", 128'(core_req_o), 128'(0));
        #1;
        rst_n = 1'b0;
        #1;
        chk_zero("t6_reset");
        @(negedge clk);
        #1;
        rst_n = 1'b1;
        tick(1);
        repeat (6) begin
            @(negedge clk);
            chk("t6_idle", 128'({busy_o, core_req_o, ct_valid_o}), '0);
        end
        pt_valid_i = 1'b0;
        pt_last_i  = 1'b0;
        tick(1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 n_cmp, n_fail);
        $finish;
    end

endmodule
